// File: rtl/iter_divider_if.sv
// Request/response bundle for the iterative divider.
// The master issues start/op/a/b and watches busy/done/result.
interface iter_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, op, a, b,
    input  busy, done, result
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result
  );
endinterface

// File: rtl/iter_divider.sv
// Multi-cycle restoring divider: div/divu/rem/remu, one quotient bit per cycle.
// Divide-by-zero and signed overflow finish immediately without iterating.
module iter_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic         clk,
  input logic         rst,
  iter_divider_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   quo_q;     // dividend shifts out the top, quotient bits shift in
  logic [WIDTH-1:0]   rem_q;     // partial remainder
  logic [WIDTH-1:0]   dvs_q;     // |divisor|
  logic [1:0]         op_q;
  logic               negq_q;
  logic               negr_q;
  logic [WIDTH-1:0]   result_q;
  logic               busy_q;
  logic               done_q;

  // operand decode for a request presented on the bus
  logic             sgn, a_neg, b_neg, b_zero, ovf, special;
  logic [WIDTH-1:0] a_abs, b_abs, spec_res;

  // Decode the incoming request: absolute values and the early-exit cases.
  always_comb begin
    sgn      = ~bus.op[0];
    a_neg    = sgn & bus.a[WIDTH-1];
    b_neg    = sgn & bus.b[WIDTH-1];
    a_abs    = a_neg ? -bus.a : bus.a;
    b_abs    = b_neg ? -bus.b : bus.b;
    b_zero   = (bus.b == '0);
    ovf      = sgn && (bus.a == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.b == '1);
    special  = b_zero | ovf;
    spec_res = '0;
    if (b_zero)
      spec_res = bus.op[1] ? bus.a : '1;
    else if (ovf)
      spec_res = bus.op[1] ? '0 : bus.a;   // quotient wraps to MIN, remainder 0
  end

  // one restoring step
  logic [WIDTH:0]   trial;
  logic             ge;
  logic [WIDTH-1:0] rem_d, quo_d, q_fix, r_fix, fin_d;

  // Shift-subtract step plus the final sign fix-up applied on the last iteration.
  always_comb begin
    trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
    ge    = ~trial[WIDTH];
    rem_d = ge ? trial[WIDTH-1:0] : {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
    quo_d = {quo_q[WIDTH-2:0], ge};
    q_fix = negq_q ? -quo_d : quo_d;
    r_fix = negr_q ? -rem_d : rem_d;
    fin_d = op_q[1] ? r_fix : q_fix;
  end

  // Control FSM with registered busy/done/result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      op_q     <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            op_q <= bus.op;
            if (special) begin
              state_q  <= S_DONE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              result_q <= spec_res;
            end else begin
              state_q <= S_CALC;
              busy_q  <= 1'b1;
              cnt_q   <= '0;
              quo_q   <= a_abs;
              rem_q   <= '0;
              dvs_q   <= b_abs;
              negq_q  <= a_neg ^ b_neg;
              negr_q  <= a_neg;
            end
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_CALC: begin
          quo_q <= quo_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH-1)) begin
            state_q  <= S_DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= fin_d;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: directed cases, handshake corners,
// mid-operation reset and randomized operands against an arithmetic model.
module tb_iter_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  iter_divider_if #(.WIDTH(32)) bus();

  iter_divider #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

  // reference: plain SV arithmetic (signed / and % truncate toward zero)
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
    case (op)
      DIV:     return 32'(sa / sb);
      DIVU:    return a / b;
      REM:     return 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op starting at a negedge. poke_at>0 pulses start (with junk
  // operands) at that cycle of the operation. chain=1 leaves the bench at the
  // done-cycle negedge so the caller can issue back-to-back.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag, input int poke_at, input bit chain);
    logic [31:0] exp;
    int          exp_lat, lat, nbusy;
    exp     = model(op, a, b);
    exp_lat = is_special(op, a, b) ? 1 : 33;
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk);
    @(negedge clk);
    lat = 1; nbusy = 0;
    bus.a = $urandom; bus.b = $urandom; bus.op = 2'($urandom);
    bus.start = (poke_at == 1);
    while (!bus.done && lat < 100) begin
      if (bus.busy) nbusy++;
      @(negedge clk);
      lat++;
      bus.start = (poke_at == lat);
      if (poke_at == lat) begin bus.op = REMU; bus.a = 32'd7; bus.b = 32'd0; end
    end
    bus.start = 1'b0;
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_res"}, bus.result, exp);
    chk({tag, "_busy"}, 32'(nbusy), (exp_lat == 1) ? 32'd0 : 32'd32);
    if (!chain) begin
      @(negedge clk);
      chk({tag, "_pulse"}, {31'd0, bus.done}, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] ra, rb, last;
    logic [1:0]  rop;
    int          lat, ndone;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_res",  bus.result, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // directed unsigned/signed
    run_op(DIVU, 32'd100, 32'd7, "divu_100_7", 0, 0);
    run_op(REMU, 32'd100, 32'd7, "remu_100_7", 0, 0);
    run_op(DIV,  32'hFFFF_FFF9, 32'd2, "div_m7_2", 0, 0);
    run_op(REM,  32'hFFFF_FFF9, 32'd2, "rem_m7_2", 0, 0);
    run_op(DIV,  32'd7, 32'hFFFF_FFFE, "div_7_m2", 0, 0);

    // result holds through idle cycles
    last = bus.result;
    repeat (4) @(negedge clk);
    chk("hold_res", bus.result, last);

    // divide by zero and overflow
    run_op(DIVU, 32'd5, 32'd0, "divu_by0", 0, 0);
    run_op(REMU, 32'd5, 32'd0, "remu_by0", 0, 0);
    run_op(DIV,  32'd5, 32'd0, "div_by0", 0, 0);
    run_op(REM,  32'hFFFF_FFFB, 32'd0, "rem_by0", 0, 0);
    run_op(DIV,  32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 0, 0);
    run_op(REM,  32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf", 0, 0);

    // start during CALC is ignored
    run_op(DIVU, 32'd1000, 32'd10, "poke_1000_10", 10, 0);

    // back-to-back: start held in the done cycle
    run_op(DIVU, 32'd1000, 32'd10, "b2b_first", 0, 1);
    run_op(DIVU, 32'd9, 32'd3, "b2b_9_3", 0, 0);
    // back-to-back into a special case
    run_op(DIVU, 32'd50, 32'd5, "b2b_first2", 0, 1);
    run_op(DIVU, 32'd9, 32'd0, "b2b_by0", 0, 0);

    // reset in the middle of a div
    bus.start = 1'b1; bus.op = DIV; bus.a = 32'hFFFF_FF9C; bus.b = 32'd3;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (lat < 15) begin @(negedge clk); lat++; end
    rst = 1'b1; bus.start = 1'b1;   // start alongside reset must be dropped
    @(negedge clk);
    rst = 1'b0; bus.start = 1'b0;
    chk("mrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mrst_done", {31'd0, bus.done}, 32'd0);
    chk("mrst_res",  bus.result, 32'd0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy) ndone++;
    end
    chk("mrst_quiet", 32'(ndone), 32'd0);
    run_op(DIVU, 32'd8, 32'd2, "post_rst_8_2", 0, 0);

    // randomized operands, with edge values mixed in
    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom);
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 20));
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op(rop, ra, rb, $sformatf("rnd%0d_op%0d", i, rop), 0, (i % 5) == 4);
    end
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iter_divider.md
Name: iter_divider

Overview:
- Multi-cycle 32-bit integer divide/remainder unit in the execute stage.
- Accepts an operation on a start pulse, computes it with a restoring shift-subtract loop, then presents a registered 32-bit result and a one-cycle done pulse.
- The result drives one data input of the 11-to-1 result-select mux. The control path holds that mux's select on this input while busy is high.

Parameters:
- WIDTH, 32, operand and result width; only 32 is verified.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only when the unit is idle or in its done cycle.
- op  input  2  operation: 00 div (signed), 01 divu, 10 rem (signed), 11 remu.
- a  input  WIDTH  dividend.
- b  input  WIDTH  divisor.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; result is valid in this cycle.
- result  output  WIDTH  quotient or remainder, selected by op; registered.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, result=0, internal counter/quotient/remainder=0.
- Reset priority: rst overrides everything, including mid-operation; the in-flight operation is discarded with no done pulse.
- States:
  - IDLE, CALC, DONE.
  - IDLE: start=1 latches op, a, b.
    - b==0, or signed op with a=0x80000000 and b=0xFFFFFFFF: go to DONE.
    - Otherwise go to CALC with counter=0.
  - CALC: one quotient bit per cycle, MSB first. After 32 iterations (counter==WIDTH-1 on the final edge) go to DONE with result loaded.
  - DONE: done=1 for exactly one cycle, busy=0. Next state is CALC/DONE if start=1 (accepted the same way as from IDLE, back-to-back), else IDLE.
- busy:
  - 1 in every CALC cycle, starting the cycle after start is sampled.
  - 0 in IDLE and DONE.
- Latency:
  - Normal op: done high 33 cycles after the edge that samples start.
  - Special case: done high 1 cycle after that edge.
- Signed ops:
  - Divide the absolute values unsigned.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Two's-complement wrap on negation, WIDTH bits.
- Divide by zero:
  - div/divu: result = 0xFFFFFFFF.
  - rem/remu: result = a.
- Signed overflow (0x80000000 / -1):
  - div: result = 0x80000000.
  - rem: result = 0.
- Result holding:
  - result holds its last value after done until the next done cycle; it is not cleared by IDLE.
  - a, b and op may change freely after the start edge (operands are latched).
- start in CALC is ignored, with no queueing; the in-progress op is unaffected.
- start and rst high together: reset wins and start is dropped.

Test Plan:
- Unsigned: divu a=100, b=7 → done 33 cycles after start, result=14. Repeat with remu → result=2. busy high for exactly 32 cycles in each case.
- Signed: div a=0xFFFFFFF9 (-7), b=2 → result=0xFFFFFFFD (-3). rem same operands → result=0xFFFFFFFF (-1). div a=7, b=0xFFFFFFFE → result=0xFFFFFFFD.
- Divide by zero: divu a=5, b=0 → done 1 cycle after start, result=0xFFFFFFFF, busy never high. remu a=5, b=0 → result=5.
- Overflow: div a=0x80000000, b=0xFFFFFFFF → result=0x80000000 after 1 cycle. rem same operands → result=0.
- Handshake:
  - start pulsed again at cycle 10 of a divu 1000/10: ignored, result=100 at cycle 33.
  - start held high in the done cycle with divu 9/3: second done 33 cycles later with result=3.
- Reset mid-op: assert rst for 1 cycle at cycle 15 of a div. The next cycle shows busy=0, done=0, result=0, and done never pulses. A fresh divu 8/2 then yields 4 after 33 cycles.
